// File: rtl/axi_stream_pkg.sv
// Shared types and defaults for the AXI-Stream header arbiter.
// Arbiter state encoding plus default widths.
package axi_stream_pkg;

  localparam int DEF_DATA_WD = 32;
  localparam int DEF_NUM_SRC = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Returns the first requester at or after rr_ptr, wrapping.
module rr_pick
  import axi_stream_pkg::*;
#(
  parameter int NUM_SRC   = DEF_NUM_SRC,
  parameter int SRC_ID_WD = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0]   req,
  input  logic [SRC_ID_WD-1:0] rr_ptr,
  output logic                 gnt_valid,
  output logic [SRC_ID_WD-1:0] gnt_idx
);

  // Scan from farthest to nearest so the nearest requester wins.
  always_comb begin
    int j;
    j         = 0;
    gnt_valid = |req;
    gnt_idx   = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_SRC) j = j - NUM_SRC;
      if (req[j]) gnt_idx = SRC_ID_WD'(j);
    end
  end

endmodule

// File: rtl/axi_stream_header_arbiter.sv
// Packet-level round-robin arbiter in front of one header inserter.
// Grant is held until both the header and the last beat are accepted.
module axi_stream_header_arbiter
  import axi_stream_pkg::*;
#(
  parameter int DATA_WD      = DEF_DATA_WD,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int NUM_SRC      = DEF_NUM_SRC,
  parameter int SRC_ID_WD    = $clog2(NUM_SRC)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_SRC-1:0]              s_valid_in,
  input  logic [NUM_SRC*DATA_WD-1:0]      s_data_in,
  input  logic [NUM_SRC*DATA_BYTE_WD-1:0] s_keep_in,
  input  logic [NUM_SRC-1:0]              s_last_in,
  output logic [NUM_SRC-1:0]              s_ready_in,
  input  logic [NUM_SRC-1:0]              s_valid_insert,
  input  logic [NUM_SRC*DATA_WD-1:0]      s_data_insert,
  input  logic [NUM_SRC*DATA_BYTE_WD-1:0] s_keep_insert,
  input  logic [NUM_SRC*BYTE_CNT_WD-1:0]  s_byte_insert_cnt,
  output logic [NUM_SRC-1:0]              s_ready_insert,
  output logic                            valid_in,
  output logic [DATA_WD-1:0]              data_in,
  output logic [DATA_BYTE_WD-1:0]         keep_in,
  output logic                            last_in,
  input  logic                            ready_in,
  output logic                            valid_insert,
  output logic [DATA_WD-1:0]              data_insert,
  output logic [DATA_BYTE_WD-1:0]         keep_insert,
  output logic [BYTE_CNT_WD-1:0]          byte_insert_cnt,
  input  logic                            ready_insert,
  output logic [SRC_ID_WD-1:0]            grant_id,
  output logic                            busy,
  output logic [15:0]                     pkt_cnt
);

  arb_state_t           r_state;
  logic [SRC_ID_WD-1:0] r_grant;
  logic [SRC_ID_WD-1:0] r_rr_ptr;
  logic                 r_hdr_done;
  logic                 r_body_done;
  logic [15:0]          r_pkt_cnt;

  logic                 w_act;
  logic                 w_gnt_valid;
  logic [SRC_ID_WD-1:0] w_gnt_idx;
  logic [SRC_ID_WD-1:0] w_next_ptr;
  logic                 w_sv_ins;
  logic                 w_sv_in;
  logic                 w_hdr_hs;
  logic                 w_body_hs;
  logic                 w_end;

  rr_pick #(
    .NUM_SRC  (NUM_SRC),
    .SRC_ID_WD(SRC_ID_WD)
  ) u_pick (
    .req      (s_valid_insert),
    .rr_ptr   (r_rr_ptr),
    .gnt_valid(w_gnt_valid),
    .gnt_idx  (w_gnt_idx)
  );

  assign w_act = (r_state == ACTIVE);

  assign w_next_ptr = (r_grant == SRC_ID_WD'(NUM_SRC - 1))
                    ? '0 : r_grant + 1'b1;

  // Mux the granted source's header and data channels forward.
  always_comb begin
    w_sv_ins        = 1'b0;
    w_sv_in         = 1'b0;
    data_insert     = '0;
    keep_insert     = '0;
    byte_insert_cnt = '0;
    data_in         = '0;
    keep_in         = '0;
    last_in         = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_grant == SRC_ID_WD'(i)) begin
        w_sv_ins        = s_valid_insert[i];
        w_sv_in         = s_valid_in[i];
        data_insert     = s_data_insert[i*DATA_WD +: DATA_WD];
        keep_insert     = s_keep_insert[i*DATA_BYTE_WD +: DATA_BYTE_WD];
        byte_insert_cnt = s_byte_insert_cnt[i*BYTE_CNT_WD +: BYTE_CNT_WD];
        data_in         = s_data_in[i*DATA_WD +: DATA_WD];
        keep_in         = s_keep_in[i*DATA_BYTE_WD +: DATA_BYTE_WD];
        last_in         = s_last_in[i];
      end
    end
  end

  assign valid_insert = w_act & ~r_hdr_done & w_sv_ins;
  assign valid_in     = w_act & ~r_body_done & w_sv_in;

  // Route inserter readies back to the granted source only.
  always_comb begin
    s_ready_insert = '0;
    s_ready_in     = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_act && (r_grant == SRC_ID_WD'(i))) begin
        s_ready_insert[i] = ready_insert & ~r_hdr_done;
        s_ready_in[i]     = ready_in & ~r_body_done;
      end
    end
  end

  assign w_hdr_hs  = valid_insert & ready_insert;
  assign w_body_hs = valid_in & ready_in & last_in;
  assign w_end     = w_act
                   & (r_hdr_done | w_hdr_hs)
                   & (r_body_done | w_body_hs);

  // Arbitration FSM: grant in IDLE, hold until header and last are done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_rr_ptr    <= '0;
      r_hdr_done  <= 1'b0;
      r_body_done <= 1'b0;
      r_pkt_cnt   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_gnt_valid) begin
            r_grant     <= w_gnt_idx;
            r_hdr_done  <= 1'b0;
            r_body_done <= 1'b0;
            r_state     <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (w_hdr_hs)  r_hdr_done  <= 1'b1;
          if (w_body_hs) r_body_done <= 1'b1;
          if (w_end) begin
            r_state   <= IDLE;
            r_rr_ptr  <= w_next_ptr;
            r_pkt_cnt <= r_pkt_cnt + 16'd1;
          end
        end
      endcase
    end
  end

  assign grant_id = r_grant;
  assign busy     = w_act;
  assign pkt_cnt  = r_pkt_cnt;

endmodule

// File: tb/tb_axi_stream_header_arbiter.sv
// Scoreboard bench for axi_stream_header_arbiter.
// Per-source queue models drive requests; a negedge monitor checks.
module tb_axi_stream_header_arbiter;

  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int CW = $clog2(BW);
  localparam int NS = 4;
  localparam int IW = $clog2(NS);

  typedef struct packed {
    logic [DW-1:0] d;
    logic [BW-1:0] k;
    logic [CW-1:0] c;
  } hdr_t;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [BW-1:0] k;
    logic          l;
  } beat_t;

  typedef struct packed {
    logic [IW-1:0] g;
    hdr_t          h;
  } exp_hdr_t;

  logic clk, rst_n;
  logic [NS-1:0]    s_valid_in, s_last_in, s_ready_in;
  logic [NS-1:0]    s_valid_insert, s_ready_insert;
  logic [NS*DW-1:0] s_data_in, s_data_insert;
  logic [NS*BW-1:0] s_keep_in, s_keep_insert;
  logic [NS*CW-1:0] s_byte_insert_cnt;
  logic valid_in, last_in, ready_in;
  logic valid_insert, ready_insert, busy;
  logic [DW-1:0] data_in, data_insert;
  logic [BW-1:0] keep_in, keep_insert;
  logic [CW-1:0] byte_insert_cnt;
  logic [IW-1:0] grant_id;
  logic [15:0]   pkt_cnt;

  axi_stream_header_arbiter #(
    .DATA_WD(DW),
    .NUM_SRC(NS)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .s_valid_in       (s_valid_in),
    .s_data_in        (s_data_in),
    .s_keep_in        (s_keep_in),
    .s_last_in        (s_last_in),
    .s_ready_in       (s_ready_in),
    .s_valid_insert   (s_valid_insert),
    .s_data_insert    (s_data_insert),
    .s_keep_insert    (s_keep_insert),
    .s_byte_insert_cnt(s_byte_insert_cnt),
    .s_ready_insert   (s_ready_insert),
    .valid_in         (valid_in),
    .data_in          (data_in),
    .keep_in          (keep_in),
    .last_in          (last_in),
    .ready_in         (ready_in),
    .valid_insert     (valid_insert),
    .data_insert      (data_insert),
    .keep_insert      (keep_insert),
    .byte_insert_cnt  (byte_insert_cnt),
    .ready_insert     (ready_insert),
    .grant_id         (grant_id),
    .busy             (busy),
    .pkt_cnt          (pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  hdr_t     hq[NS][$];
  beat_t    dq[NS][$];
  exp_hdr_t eh[$];
  beat_t    ed[$];
  logic [IW-1:0] glog[$];
  int       ilog[$];

  int errors = 0;
  int checks = 0;
  int hcnt = 0;
  int dcnt = 0;

  logic [NS-1:0] hs_h, hs_d;
  logic m_hdr, m_body, end_pend, prev_busy;
  logic prev_vh, prev_rh, prev_vd, prev_rd, prev_ld;
  logic [DW-1:0] prev_dh, prev_dd;
  logic [BW-1:0] prev_kh, prev_kd;
  logic [CW-1:0] prev_ch;
  int idle_run;
  exp_hdr_t e;
  beat_t    eb;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NS; i++) begin
      if (hq[i].size() != 0) begin
        s_valid_insert[i]            = 1'b1;
        s_data_insert[i*DW +: DW]    = hq[i][0].d;
        s_keep_insert[i*BW +: BW]    = hq[i][0].k;
        s_byte_insert_cnt[i*CW +: CW] = hq[i][0].c;
      end else begin
        s_valid_insert[i]            = 1'b0;
        s_data_insert[i*DW +: DW]    = '0;
        s_keep_insert[i*BW +: BW]    = '0;
        s_byte_insert_cnt[i*CW +: CW] = '0;
      end
      if (dq[i].size() != 0) begin
        s_valid_in[i]         = 1'b1;
        s_data_in[i*DW +: DW] = dq[i][0].d;
        s_keep_in[i*BW +: BW] = dq[i][0].k;
        s_last_in[i]          = dq[i][0].l;
      end else begin
        s_valid_in[i]         = 1'b0;
        s_data_in[i*DW +: DW] = '0;
        s_keep_in[i*BW +: BW] = '0;
        s_last_in[i]          = 1'b0;
      end
    end
  endtask

  // Queue one packet at a source and its expected forwarded words.
  task automatic send(input int src, input int nb, input int tag);
    hdr_t  h;
    beat_t b;
    h.d = 32'(32'hA500_0000 + tag * 256 + src);
    h.k = src[0] ? 4'hE : 4'hF;
    h.c = CW'(src);
    hq[src].push_back(h);
    eh.push_back({IW'(src), h});
    for (int j = 0; j < nb; j++) begin
      b.d = 32'(32'hD000_0000 + tag * 256 + j);
      b.k = (j == nb - 1) ? 4'h3 : 4'hF;
      b.l = (j == nb - 1);
      dq[src].push_back(b);
      ed.push_back(b);
    end
    drive();
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || eh.size() != 0 || ed.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_timeout"}, 64'(n < 200), 1);
    @(posedge clk);
    #2;
  endtask

  // Source models: retire the words accepted at the last edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++) begin
        if (hs_h[i] && hq[i].size() != 0) void'(hq[i].pop_front());
        if (hs_d[i] && dq[i].size() != 0) void'(dq[i].pop_front());
      end
      drive();
    end
  end

  // Monitor and scoreboard.
  always @(negedge clk) begin
    hs_h = s_valid_insert & s_ready_insert;
    hs_d = s_valid_in & s_ready_in;
    if (!rst_n) begin
      chk("reset_outs", {valid_insert, valid_in, s_ready_in,
                         s_ready_insert, busy}, '0);
      m_hdr = 0; m_body = 0; end_pend = 0; prev_busy = 0;
      prev_vh = 0; prev_vd = 0; idle_run = 0;
    end else begin
      if (prev_busy) chk("pkt_end", 64'(!busy), 64'(end_pend));
      if (prev_vh && !prev_rh)
        chk("hdr_hold", {valid_insert, data_insert, keep_insert,
                         byte_insert_cnt},
            {1'b1, prev_dh, prev_kh, prev_ch});
      if (prev_vd && !prev_rd)
        chk("data_hold", {valid_in, data_in, keep_in, last_in},
            {1'b1, prev_dd, prev_kd, prev_ld});
      if (!busy) begin
        chk("idle_outs", {valid_insert, valid_in, s_ready_in,
                          s_ready_insert}, '0);
        m_hdr = 0;
        m_body = 0;
      end else begin
        if (!prev_busy) begin
          glog.push_back(grant_id);
          ilog.push_back(idle_run);
        end
        chk("ready_leak",
            (s_ready_in | s_ready_insert) & ~(NS'(1) << grant_id), '0);
        chk("hdr_fwd", valid_insert, s_valid_insert[grant_id] & !m_hdr);
        chk("data_fwd", valid_in, s_valid_in[grant_id] & !m_body);
        chk("hdr_rdy", s_ready_insert[grant_id], ready_insert & !m_hdr);
        chk("data_rdy", s_ready_in[grant_id], ready_in & !m_body);
        if (valid_insert && ready_insert) begin
          hcnt++;
          chk("dup_hdr", m_hdr, 0);
          chk("hdr_expected", 64'(eh.size() != 0), 1);
          if (eh.size() != 0) begin
            e = eh.pop_front();
            chk("hdr_grant", grant_id, e.g);
            chk("hdr_word", {data_insert, keep_insert, byte_insert_cnt},
                {e.h.d, e.h.k, e.h.c});
          end
          m_hdr = 1;
        end
        if (valid_in && ready_in) begin
          dcnt++;
          chk("data_expected", 64'(ed.size() != 0), 1);
          if (ed.size() != 0) begin
            eb = ed.pop_front();
            chk("data_word", {data_in, keep_in, last_in},
                {eb.d, eb.k, eb.l});
            if (eb.l) m_body = 1;
          end
        end
      end
      end_pend = busy && m_hdr && m_body;
      idle_run = busy ? 0 : idle_run + 1;
      prev_busy = busy;
      prev_vh = valid_insert; prev_rh = ready_insert;
      prev_dh = data_insert;  prev_kh = keep_insert;
      prev_ch = byte_insert_cnt;
      prev_vd = valid_in;     prev_rd = ready_in;
      prev_dd = data_in;      prev_kd = keep_in;
      prev_ld = last_in;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int hb, db, n;
    rst_n = 1'b1;
    ready_in = 1'b0;
    ready_insert = 1'b0;
    drive();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_cnt", pkt_cnt, 0);
    rst_n = 1'b1;
    ready_in = 1'b1;
    ready_insert = 1'b1;

    glog.delete(); ilog.delete();
    send(0, 1, 1); send(1, 1, 2); send(2, 1, 3);
    send(3, 1, 4); send(0, 1, 5);
    wait_done("contention");
    chk("order_len", glog.size(), 5);
    for (int i = 0; i < glog.size() && i < 5; i++)
      chk("order", glog[i], exp_order[i]);
    for (int i = 1; i < ilog.size(); i++)
      chk("bubble", ilog[i], 1);
    chk("cnt_contention", pkt_cnt, 5);

    hb = hcnt; db = dcnt;
    glog.delete();
    send(2, 3, 6);
    wait_done("single");
    chk("single_hdrs", hcnt - hb, 1);
    chk("single_beats", dcnt - db, 3);
    chk("single_grant", grant_id, 2);
    if (glog.size() != 0) chk("single_glog", glog[0], 2);
    chk("single_cnt", pkt_cnt, 6);
    chk("single_busy", busy, 0);

    ready_insert = 1'b0;
    glog.delete();
    send(1, 4, 7);
    repeat (5) begin
      @(posedge clk);
      #2;
      ready_in = ~ready_in;
    end
    chk("bp_busy", busy, 1);
    chk("bp_grant", grant_id, 1);
    ready_insert = 1'b1;
    ready_in = 1'b1;
    wait_done("backpressure");
    chk("bp_cnt", pkt_cnt, 7);

    ready_insert = 1'b0;
    db = dcnt;
    send(3, 1, 8);
    repeat (4) @(posedge clk);
    #2;
    chk("lbh_busy", busy, 1);
    chk("lbh_grant", grant_id, 3);
    chk("lbh_valid_in", valid_in, 0);
    chk("lbh_beats", dcnt - db, 1);
    chk("lbh_cnt_hold", pkt_cnt, 7);
    ready_insert = 1'b1;
    wait_done("last_first");
    chk("lbh_cnt", pkt_cnt, 8);

    db = dcnt;
    n = 0;
    send(1, 4, 9);
    while (dcnt - db < 2 && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("mid_wait", 64'(n < 20), 1);
    ready_in = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_outs", {valid_insert, valid_in, s_ready_in,
                     s_ready_insert, busy}, '0);
    chk("mid_grant", grant_id, 0);
    chk("mid_cnt", pkt_cnt, 0);
    for (int i = 0; i < NS; i++) begin
      hq[i].delete();
      dq[i].delete();
    end
    eh.delete();
    ed.delete();
    drive();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    ready_in = 1'b1;
    glog.delete();
    send(1, 2, 10);
    wait_done("after_reset");
    if (glog.size() != 0) chk("ar_grant", glog[0], 1);
    chk("ar_cnt", pkt_cnt, 1);

    force dut.r_pkt_cnt = 16'hFFFE;
    @(posedge clk);
    #2;
    release dut.r_pkt_cnt;
    @(posedge clk);
    #2;
    chk("wrap_pre", pkt_cnt, 16'hFFFE);
    send(0, 1, 11);
    wait_done("wrap_a");
    chk("wrap_ffff", pkt_cnt, 16'hFFFF);
    send(2, 1, 12);
    wait_done("wrap_b");
    chk("wrap_zero", pkt_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_stream_header_arbiter.md
# axi_stream_header_arbiter

Packet-level round-robin arbiter that shares one `axi_stream_insert_header` instance between NUM_SRC requesters. Each requester owns a header channel and a data stream. The arbiter grants one requester per packet and muxes that requester's header and data channels onto the inserter's insert/in ports. The grant is held from arbitration until both the header and the `last` data beat have been accepted. The block sits directly upstream of the inserter; the inserter's output stream is not touched.

## Interface
- DATA_WD, 32, data width in bits
- DATA_BYTE_WD, DATA_WD/8, bytes per beat
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD), width of byte_insert_cnt
- NUM_SRC, 4, number of requesters (≥2)
- SRC_ID_WD, $clog2(NUM_SRC), grant index width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- s_valid_in  in  NUM_SRC  per-source data valid
- s_data_in  in  NUM_SRC*DATA_WD  per-source data, source i at [i*DATA_WD +: DATA_WD]
- s_keep_in  in  NUM_SRC*DATA_BYTE_WD  per-source keep
- s_last_in  in  NUM_SRC  per-source last
- s_ready_in  out  NUM_SRC  per-source data ready
- s_valid_insert  in  NUM_SRC  per-source header valid; this is the request
- s_data_insert  in  NUM_SRC*DATA_WD  per-source header
- s_keep_insert  in  NUM_SRC*DATA_BYTE_WD  per-source header keep
- s_byte_insert_cnt  in  NUM_SRC*BYTE_CNT_WD  per-source header byte count
- s_ready_insert  out  NUM_SRC  per-source header ready
- valid_in, data_in, keep_in, last_in  out  1/DATA_WD/DATA_BYTE_WD/1  to inserter data port
- ready_in  in  1  from inserter
- valid_insert, data_insert, keep_insert, byte_insert_cnt  out  1/DATA_WD/DATA_BYTE_WD/BYTE_CNT_WD  to inserter header port
- ready_insert  in  1  from inserter
- grant_id  out  SRC_ID_WD  registered index of the granted source
- busy  out  1  high while in ACTIVE
- pkt_cnt  out  16  count of completed packets; wraps at 16'hFFFF

## Operation
- State machine with two states: IDLE and ACTIVE.
- IDLE:
  - If any s_valid_insert bit is high, select the first requesting source at or after rr_ptr, wrapping modulo NUM_SRC.
  - Register the selection in grant_id, clear hdr_done and body_done, and go to ACTIVE.
  - With no request, stay in IDLE.
- ACTIVE muxing:
  - Combinationally forward the granted source's header and data channels to the inserter.
  - Route ready_insert/ready_in back only to s_ready_insert[grant_id] and s_ready_in[grant_id]. All other s_ready_* bits are 0.
  - Once hdr_done=1, force valid_insert to 0 so a second header is never presented.
  - Once body_done=1, force valid_in to 0.
- Completion flags:
  - hdr_done is set on valid_insert&ready_insert.
  - body_done is set on valid_in&ready_in&last_in.
- Packet end:
  - The packet ends in the cycle where both flags are set, either already registered or handshaking in this cycle.
  - On packet end: go to IDLE, set rr_ptr = grant_id+1 mod NUM_SRC, and increment pkt_cnt.
- Grant stability: the grant is never revoked by a requester dropping valid mid-packet. Dropping valid is illegal per AXI-Stream, and the arbiter keeps waiting.
- Out-of-order completion: a data `last` accepted before the header is legal for the arbiter. It holds ACTIVE until the header handshake also occurs.

## Timing
- Reset values: state=IDLE, grant_id=0, rr_ptr=0, hdr_done=0, body_done=0, busy=0, pkt_cnt=0.
- All valid/ready outputs are 0 in IDLE and while rst_n=0.
- Request-to-present latency is 1 cycle: the request is seen in IDLE at edge N, and the granted channels appear on the outputs after edge N+1.
- Muxed paths are zero-latency combinational; there is no extra register stage on data.
- There is one IDLE bubble cycle between consecutive packets, including back-to-back packets from the same source.
- Simultaneous header and last handshake in one cycle: the packet ends at that edge.
- Reset asserted mid-packet: return immediately (asynchronously) to IDLE, drop all readies, and reset pkt_cnt. The partially transferred packet is abandoned.

## Structure
- Shared package `axi_stream_pkg`:
  - arbiter state encoding (IDLE=1'b0, ACTIVE=1'b1)
  - default DATA_WD / NUM_SRC constants
- Sub-module `rr_pick`: combinational round-robin priority picker.
  - Inputs: req[NUM_SRC] and rr_ptr.
  - Outputs: gnt_valid and gnt_idx.
  - Instantiated once.
- The FSM and muxes live in the top module.

## Test plan
- Single source: source 2 sends a header plus 3 beats with last on beat 3, ready always 1. Expect grant_id=2, exactly 1 header and 3 data handshakes forwarded, pkt_cnt=1, busy low again after the last beat plus one cycle.
- Contention: all 4 sources request continuously, one 1-beat packet each. Expect grant order 0,1,2,3,0 with one IDLE cycle between grants.
- Backpressure: ready_insert=0 for 5 cycles and ready_in toggling. Expect the granted source's valid/data held stable, non-granted s_ready_* always 0, and no duplicate header.
- Last before header: ready_insert held 0 while the source's 1-beat packet with last is accepted. Expect the arbiter to stay ACTIVE with valid_in=0, then end the packet on the header handshake.
- Reset mid-packet: assert rst_n=0 after 2 of 4 beats. Expect all outputs 0 immediately, grant_id=0 and pkt_cnt=0. After release, a new request from source 1 is granted normally.
- pkt_cnt wrap: preload by running 65536 1-beat packets (or force the counter). Expect 16'hFFFF to roll over to 0.
